pwm_param_loader: RTL and testbench

Sequencer that loads per-transducer duty/phase from a parameter RAM into shadow registers, then commits all of them atomically on an update boundary. It sits between the CPU-written parameter RAM and the transducer PWM array, so every PWM generator switches to the new DUTY/PHASE set in the same cycle and never mid-period.

---
 rtl/pwm_param_loader_if.sv | 31 +++
 rtl/pwm_param_loader.sv | 121 ++++++++++++
 tb/tb_pwm_param_loader.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_param_loader_if.sv
// Load handshake and parameter-RAM read port between the CPU side and the PWM loader.
// The slave modport is the loader; the master modport is the requester/RAM side.
interface pwm_param_loader_if #(
  parameter int unsigned WIDTH      = 13,
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                  load_req;
  logic                  load_busy;
  logic                  load_done;
  logic                  ram_en;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [2*WIDTH-1:0]    ram_data;

  modport master (
    output load_req,
    output ram_data,
    input  load_busy,
    input  load_done,
    input  ram_en,
    input  ram_addr
  );

  modport slave (
    input  load_req,
    input  ram_data,
    output load_busy,
    output load_done,
    output ram_en,
    output ram_addr
  );
endinterface

// File: rtl/pwm_param_loader.sv
// Streams duty/phase for every transducer from the parameter RAM into shadow registers,
// then commits the whole set to the PWM array on one period tick.
module pwm_param_loader #(
  parameter int unsigned WIDTH      = 13,
  parameter int unsigned TRANS_NUM  = 249,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [WIDTH-1:0]                i_update_cycle,
  pwm_param_loader_if.slave               io_bus,
  output logic                            o_update,
  output logic [TRANS_NUM-1:0][WIDTH-1:0] o_duty,
  output logic [TRANS_NUM-1:0][WIDTH-1:0] o_phase
);

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StWaitTick} state_e;

  state_e                          r_state;
  logic [WIDTH-1:0]                r_cnt;
  logic                            r_update;
  logic                            r_ram_en;
  logic [ADDR_WIDTH-1:0]           r_ram_addr;
  logic                            r_busy;
  logic                            r_done;
  logic                            r_en_d;
  logic [ADDR_WIDTH-1:0]           r_addr_d;
  logic [TRANS_NUM-1:0][WIDTH-1:0] r_shadow_duty;
  logic [TRANS_NUM-1:0][WIDTH-1:0] r_shadow_phase;
  logic [TRANS_NUM-1:0][WIDTH-1:0] r_duty;
  logic [TRANS_NUM-1:0][WIDTH-1:0] r_phase;
  logic [WIDTH-1:0]                w_last;

  // A period of 0 behaves as 1; >= lets a shrunk period wrap on the very next edge.
  assign w_last = (i_update_cycle == '0) ? '0 : i_update_cycle - WIDTH'(1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt    <= '0;
      r_update <= 1'b0;
    end else if (r_cnt >= w_last) begin
      r_cnt    <= '0;
      r_update <= 1'b1;
    end else begin
      r_cnt    <= r_cnt + WIDTH'(1);
      r_update <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_ram_en   <= 1'b0;
      r_ram_addr <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_duty     <= '0;
      r_phase    <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (io_bus.load_req) begin
            r_state    <= StRead;
            r_ram_en   <= 1'b1;
            r_ram_addr <= '0;
            r_busy     <= 1'b1;
          end
        end
        StRead: begin
          if (r_ram_addr == ADDR_WIDTH'(TRANS_NUM - 1)) begin
            r_state  <= StDrain;
            r_ram_en <= 1'b0;
          end else begin
            r_ram_addr <= r_ram_addr + ADDR_WIDTH'(1);
          end
        end
        StDrain: r_state <= StWaitTick;
        StWaitTick: begin
          // r_update is the tick visible this cycle, so the commit lands on its closing edge.
          if (r_update) begin
            r_duty  <= r_shadow_duty;
            r_phase <= r_shadow_phase;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_en_d   <= 1'b0;
      r_addr_d <= '0;
    end else begin
      r_en_d   <= r_ram_en;
      r_addr_d <= r_ram_addr;
    end
  end

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < int'(TRANS_NUM); i++) begin
      if (r_en_d && (r_addr_d == ADDR_WIDTH'(i))) begin
        r_shadow_duty[i]  <= io_bus.ram_data[2*WIDTH-1:WIDTH];
        r_shadow_phase[i] <= io_bus.ram_data[WIDTH-1:0];
      end
    end
  end

  assign io_bus.ram_en    = r_ram_en;
  assign io_bus.ram_addr  = r_ram_addr;
  assign io_bus.load_busy = r_busy;
  assign io_bus.load_done = r_done;
  assign o_update         = r_update;
  assign o_duty           = r_duty;
  assign o_phase          = r_phase;

endmodule

// File: tb/tb_pwm_param_loader.sv
// Random loads against a timing/data reference model; a scoreboard queue holds each
// load's expected window and payload, and a negedge monitor checks every cycle.
module tb_pwm_param_loader;
  localparam int N  = 4;
  localparam int W  = 13;
  localparam int AW = 2;

  typedef struct {
    int                  k;
    int                  done;
    logic [N-1:0][W-1:0] duty;
    logic [N-1:0][W-1:0] phase;
  } load_t;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [W-1:0]        upd_cycle = '0;
  logic                upd;
  logic [N-1:0][W-1:0] duty;
  logic [N-1:0][W-1:0] phase;

  logic [2*W-1:0]      ram [N];
  load_t               sb[$];
  logic [N-1:0][W-1:0] m_duty = '0;
  logic [N-1:0][W-1:0] m_phase = '0;
  int                  cyc = 0;
  int                  upd_base = 1;
  int                  upd_per = 1;
  int                  tests = 0;
  int                  fails = 0;

  pwm_param_loader_if #(.WIDTH(W), .ADDR_WIDTH(AW)) bus ();

  pwm_param_loader #(.WIDTH(W), .TRANS_NUM(N), .ADDR_WIDTH(AW)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_update_cycle (upd_cycle),
    .io_bus         (bus),
    .o_update       (upd),
    .o_duty         (duty),
    .o_phase        (phase)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  always @(posedge clk) begin
    if (bus.ram_en) bus.ram_data <= ram[bus.ram_addr];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // Tick cycles form an arithmetic progression from upd_base with stride upd_per.
  function automatic bit is_upd(input int c);
    return (c >= upd_base) && (((c - upd_base) % upd_per) == 0);
  endfunction

  function automatic int compute_done(input int k);
    int d = k + N + 2;
    while (!is_upd(d)) d++;
    return d + 1;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      logic exp_en, exp_busy, exp_done;
      exp_en   = 1'b0;
      exp_busy = 1'b0;
      exp_done = 1'b0;
      if (sb.size() > 0) begin
        exp_en   = (cyc >= sb[0].k + 1) && (cyc <= sb[0].k + N);
        exp_busy = (cyc >= sb[0].k + 1) && (cyc < sb[0].done);
        exp_done = (cyc == sb[0].done);
      end
      chk("update", 64'(upd), 64'(is_upd(cyc)));
      chk("ram_en", 64'(bus.ram_en), 64'(exp_en));
      if (exp_en) chk("ram_addr", 64'(bus.ram_addr), 64'(cyc - sb[0].k - 1));
      chk("load_busy", 64'(bus.load_busy), 64'(exp_busy));
      chk("load_done", 64'(bus.load_done), 64'(exp_done));
      if (exp_done) begin
        m_duty  = sb[0].duty;
        m_phase = sb[0].phase;
        void'(sb.pop_front());
      end
      chk("duty", 64'(duty), 64'(m_duty));
      chk("phase", 64'(phase), 64'(m_phase));
    end
  end

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_busy"}, 64'(bus.load_busy), 64'd0);
    chk({tag, "_done"}, 64'(bus.load_done), 64'd0);
    chk({tag, "_ram_en"}, 64'(bus.ram_en), 64'd0);
    chk({tag, "_ram_addr"}, 64'(bus.ram_addr), 64'd0);
    chk({tag, "_update"}, 64'(upd), 64'd0);
    chk({tag, "_duty"}, 64'(duty), 64'd0);
    chk({tag, "_phase"}, 64'(phase), 64'd0);
  endtask

  task automatic start_phase(input int p);
    @(negedge clk);
    rst = 1'b1;
    bus.load_req = 1'b0;
    sb.delete();
    m_duty  = '0;
    m_phase = '0;
    upd_cycle = W'(p);
    upd_base  = (p == 0) ? 1 : p;
    upd_per   = upd_base;
    @(negedge clk);
    rst = 1'b0;
    #1 check_zero_outputs("reset");
  endtask

  task automatic fill_ram(input bit plan);
    for (int i = 0; i < N; i++)
      ram[i] = plan ? {W'(i + 1), W'(10 * i)} : {W'($urandom), W'($urandom)};
  endtask

  task automatic push_entry(input int k);
    load_t e;
    e.k    = k;
    e.done = compute_done(k);
    for (int i = 0; i < N; i++) begin
      e.duty[i]  = ram[i][2*W-1:W];
      e.phase[i] = ram[i][W-1:0];
    end
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (sb.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL load_timeout cycle=%0d got=pending want=done", cyc);
      sb.delete();
    end
  endtask

  // Call at a negedge with the loader idle; poke adds a stray request mid-READ.
  task automatic issue_load(input bit plan, input bit poke);
    fill_ram(plan);
    push_entry(cyc);
    bus.load_req = 1'b1;
    @(negedge clk);
    bus.load_req = 1'b0;
    if (poke) begin
      @(negedge clk);
      bus.load_req = 1'b1;
      @(negedge clk);
      bus.load_req = 1'b0;
    end
    wait_idle();
  endtask

  task automatic random_loads(input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 20)) @(negedge clk);
      issue_load(1'b0, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    int d1;
    bus.load_req = 1'b0;
    repeat (3) @(posedge clk);

    start_phase(16);
    repeat (2) @(negedge clk);
    issue_load(1'b1, 1'b0);
    random_loads(3);
    issue_load(1'b0, 1'b1);

    // Tick lands on the DRAIN cycle: the commit must wait for the following tick.
    @(negedge clk);
    while (((cyc + N + 1) % 16) != 0) @(negedge clk);
    issue_load(1'b0, 1'b0);

    // Request held high across a whole load re-triggers straight after completion.
    @(negedge clk);
    fill_ram(1'b0);
    push_entry(cyc);
    d1 = sb[sb.size()-1].done;
    push_entry(d1);
    bus.load_req = 1'b1;
    while (cyc < d1 + 1) @(negedge clk);
    bus.load_req = 1'b0;
    wait_idle();

    // Asynchronous reset in the middle of READ, after a committed set is live.
    @(negedge clk);
    fill_ram(1'b0);
    push_entry(cyc);
    bus.load_req = 1'b1;
    @(negedge clk);
    bus.load_req = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_zero_outputs("async_rst");
    sb.delete();
    m_duty  = '0;
    m_phase = '0;

    start_phase(0);
    random_loads(3);
    start_phase(1);
    random_loads(2);
    start_phase(int'($urandom_range(2, 40)));
    random_loads(4);

    // Period shrinks from 100 to 5 while the counter sits at 50.
    start_phase(100);
    while (cyc < 50) @(negedge clk);
    upd_cycle = W'(5);
    upd_base  = 51;
    upd_per   = 5;
    repeat (3) @(negedge clk);
    issue_load(1'b0, 1'b0);
    repeat (20) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
